// File: rtl/rv_pkg.sv
// Shared RV64I issue-stage definitions: opcodes, ALU op_sel codes, immediate kinds.
package rv_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;

  typedef enum logic [1:0] {
    ImmNone,
    ImmI,
    ImmShamt,
    ImmU
  } imm_type_e;

  // Builds the 64-bit immediate operand for the given immediate kind.
  function automatic logic [63:0] gen_imm(imm_type_e imm_type, logic [31:0] instr);
    logic [63:0] imm;
    case (imm_type)
      ImmI:     imm = {{52{instr[31]}}, instr[31:20]};
      ImmShamt: imm = {58'b0, instr[25:20]};
      ImmU:     imm = {{32{instr[31]}}, instr[31:12], 12'b0};
      default:  imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/rv_skid_buf.sv
// Generic 2-entry valid/ready buffer: an output register plus one skid entry.
module rv_skid_buf #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [Width-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [Width-1:0] out_data_o
);

  logic             out_valid_q, out_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic [Width-1:0] out_data_q, out_data_d;
  logic [Width-1:0] skid_data_q, skid_data_d;
  logic             in_fire, out_fire;

  // Ready is purely a flop output: accept whenever the skid slot is free.
  assign in_ready_o  = ~skid_valid_q;
  assign in_fire     = in_valid_i & ~skid_valid_q;
  assign out_fire    = out_valid_q & out_ready_i;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;

  // Next-state: refill the output register from skid first, then from the input.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (flush_i) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || out_fire) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        out_valid_d = 1'b1;
        out_data_d  = in_data_i;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      // Output stalled: the bundle in flight parks in the skid entry.
      skid_valid_d = 1'b1;
      skid_data_d  = in_data_i;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      out_data_q   <= '0;
      skid_data_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      out_data_q   <= out_data_d;
      skid_data_q  <= skid_data_d;
    end
  end

endmodule

// File: rtl/rv_alu_issue.sv
// RV64I execute-stage issue: decodes operands/op_sel and registers them for the ALU.
module rv_alu_issue
  import rv_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     instr_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] op1_o,
  output logic [XLEN-1:0] op2_o,
  output logic [3:0]      op_sel_o,
  output logic            illegal_o,
  output logic [XLEN-1:0] pc_o
);

  localparam int unsigned PayloadW = 3 * XLEN + 4 + 1;

  logic [6:0]          opcode;
  logic [2:0]          funct3;
  logic [6:0]          funct7;
  logic                dec_legal;
  logic [XLEN-1:0]     dec_op1, dec_op2;
  logic [3:0]          dec_sel;
  imm_type_e           imm_type;
  logic [PayloadW-1:0] in_payload, out_payload;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];

  // Combinational decode; illegal encodings collapse to a zeroed ADD bundle.
  always_comb begin
    dec_legal = 1'b0;
    dec_op1   = '0;
    dec_op2   = '0;
    dec_sel   = ALU_ADD;
    imm_type  = ImmNone;
    case (opcode)
      OPC_OP: begin
        dec_legal = (funct7 == 7'b0000000) ||
                    ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
        dec_op1   = rs1_data_i;
        // The ALU shifts by the whole op2, so register shifts must be masked here.
        dec_op2   = (funct3[1:0] == 2'b01) ? {58'b0, rs2_data_i[5:0]} : rs2_data_i;
        dec_sel   = {funct7[5], funct3};
      end
      OPC_OP_IMM: begin
        dec_legal = 1'b1;
        dec_op1   = rs1_data_i;
        dec_sel   = {1'b0, funct3};
        imm_type  = ImmI;
        if (funct3 == 3'b001) begin
          imm_type  = ImmShamt;
          dec_legal = (instr_i[31:26] == 6'b000000);
        end else if (funct3 == 3'b101) begin
          imm_type   = ImmShamt;
          dec_legal  = (instr_i[31:26] == 6'b000000) || (instr_i[31:26] == 6'b010000);
          dec_sel[3] = instr_i[30];
        end
        dec_op2 = gen_imm(imm_type, instr_i);
      end
      OPC_LUI: begin
        dec_legal = 1'b1;
        imm_type  = ImmU;
        dec_op2   = gen_imm(imm_type, instr_i);
      end
      OPC_AUIPC: begin
        dec_legal = 1'b1;
        imm_type  = ImmU;
        dec_op1   = pc_i;
        dec_op2   = gen_imm(imm_type, instr_i);
      end
      default: ;
    endcase
    if (!dec_legal) begin
      dec_op1 = '0;
      dec_op2 = '0;
      dec_sel = ALU_ADD;
    end
  end

  assign in_payload = {pc_i, dec_op1, dec_op2, dec_sel, ~dec_legal};

  rv_skid_buf #(
    .Width(PayloadW)
  ) u_skid_buf (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .flush_i    (flush_i),
    .in_valid_i (in_valid_i),
    .in_ready_o (in_ready_o),
    .in_data_i  (in_payload),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i),
    .out_data_o (out_payload)
  );

  assign {pc_o, op1_o, op2_o, op_sel_o, illegal_o} = out_payload;

endmodule

// File: tb/tb_rv_alu_issue.sv
// Self-checking bench for rv_alu_issue: directed cases plus a randomized stream
// compared against a queue-based reference model.
module tb_rv_alu_issue;

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] op1;
    logic [63:0] op2;
    logic [3:0]  sel;
    logic        ill;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] instr = '0;
  logic [63:0] pc = '0;
  logic [63:0] rs1 = '0;
  logic [63:0] rs2 = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] op1, op2, pc_out;
  logic [3:0]  op_sel;
  logic        illegal;

  int   total = 0;
  int   bad = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  rv_alu_issue #(
    .XLEN(64)
  ) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .flush_i    (flush),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .instr_i    (instr),
    .pc_i       (pc),
    .rs1_data_i (rs1),
    .rs2_data_i (rs2),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .op1_o      (op1),
    .op2_o      (op2),
    .op_sel_o   (op_sel),
    .illegal_o  (illegal),
    .pc_o       (pc_out)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    assert (got === want)
    else begin
      bad++;
      $error("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Reference decode, written from the instruction-set rules with plain arithmetic.
  function automatic exp_t ref_model(input logic [31:0] ins, input logic [63:0] ipc,
                                     input logic [63:0] a, input logic [63:0] b);
    exp_t        e;
    int          f3, f7, imm, opc;
    logic [63:0] simm, uimm;
    opc  = int'(ins[6:0]);
    f3   = int'(ins[14:12]);
    f7   = int'(ins[31:25]);
    imm  = int'(ins[31:20]);
    simm = (imm >= 2048) ? 64'(imm) - 64'd4096 : 64'(imm);
    uimm = 64'(ins[31:12]) * 64'd4096;
    if (ins[31]) uimm = uimm - 64'h1_0000_0000;
    e.pc  = ipc;
    e.op1 = '0;
    e.op2 = '0;
    e.sel = 4'd0;
    e.ill = 1'b1;
    if (opc == 'h33) begin
      if (f7 == 0 || (f7 == 'h20 && (f3 == 0 || f3 == 5))) begin
        e.ill = 1'b0;
        e.op1 = a;
        e.op2 = (f3 == 1 || f3 == 5) ? b % 64'd64 : b;
        e.sel = 4'(f3 + ((f7 == 'h20) ? 8 : 0));
      end
    end else if (opc == 'h13) begin
      if (f3 == 1) begin
        if (imm / 64 == 0) begin
          e.ill = 1'b0; e.op1 = a; e.op2 = 64'(imm % 64); e.sel = 4'd1;
        end
      end else if (f3 == 5) begin
        if (imm / 64 == 0 || imm / 64 == 16) begin
          e.ill = 1'b0; e.op1 = a; e.op2 = 64'(imm % 64);
          e.sel = (imm / 64 == 16) ? 4'd13 : 4'd5;
        end
      end else begin
        e.ill = 1'b0; e.op1 = a; e.op2 = simm; e.sel = 4'(f3);
      end
    end else if (opc == 'h37) begin
      e.ill = 1'b0; e.op2 = uimm;
    end else if (opc == 'h17) begin
      e.ill = 1'b0; e.op1 = ipc; e.op2 = uimm;
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom();
    case ($urandom_range(0, 7))
      0, 1: begin
        r[6:0] = 7'h33;
        case ($urandom_range(0, 3))
          0: r[31:25] = 7'h00;
          1: r[31:25] = 7'h20;
          2: r[31:25] = 7'h01;
          default: ;
        endcase
      end
      2, 3: begin
        r[6:0] = 7'h13;
        if ($urandom_range(0, 1) == 1) r[31:26] = ($urandom_range(0, 1) == 1) ? 6'h00 : 6'h10;
      end
      4: r[6:0] = 7'h37;
      5: r[6:0] = 7'h17;
      6: r[6:0] = 7'h03;
      default: ;
    endcase
    return r;
  endfunction

  // One clock cycle: compare outputs with the model, then advance model on the edge.
  task automatic cycle();
    logic in_fire, out_fire;
    exp_t e;
    chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
    chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
    if (q.size() > 0) begin
      chk("pc", pc_out, q[0].pc);
      chk("op1", op1, q[0].op1);
      chk("op2", op2, q[0].op2);
      chk("op_sel", 64'(op_sel), 64'(q[0].sel));
      chk("illegal", 64'(illegal), 64'(q[0].ill));
    end
    in_fire  = in_valid && in_ready;
    out_fire = out_valid && out_ready;
    e = ref_model(instr, pc, rs1, rs2);
    @(posedge clk);
    #1;
    if (flush) begin
      q.delete();
    end else begin
      if (out_fire) void'(q.pop_front());
      if (in_fire) q.push_back(e);
    end
  endtask

  task automatic issue(input logic [31:0] i, input logic [63:0] p, input logic [63:0] a,
                       input logic [63:0] b);
    instr = i; pc = p; rs1 = a; rs2 = b;
    in_valid = 1'b1; out_ready = 1'b1; flush = 1'b0;
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic chk_bundle(input string tag, input logic [63:0] w1, input logic [63:0] w2,
                            input logic [3:0] ws, input logic wi);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_op1"}, op1, w1);
    chk({tag, "_op2"}, op2, w2);
    chk({tag, "_sel"}, 64'(op_sel), 64'(ws));
    chk({tag, "_ill"}, 64'(illegal), 64'(wi));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "_op1"}, op1, 64'd0);
    chk({tag, "_op2"}, op2, 64'd0);
    chk({tag, "_pc"}, pc_out, 64'd0);
    chk({tag, "_sel"}, 64'(op_sel), 64'd0);
    chk({tag, "_ill"}, 64'(illegal), 64'd0);
  endtask

  initial begin
    logic [3:0] rdy;
    #1 rst_n = 1'b0;
    #2 chk_reset("reset");
    #9 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed decode cases, back to back.
    issue({7'b0100000, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011}, 64'h10, 64'd10, 64'd3);
    chk_bundle("sub", 64'd10, 64'd3, 4'b1000, 1'b0);
    issue({7'b0000000, 5'd2, 5'd1, 3'b001, 5'd3, 7'b0110011}, 64'h14, 64'h55, 64'h41);
    chk_bundle("sll", 64'h55, 64'h1, 4'b0001, 1'b0);
    issue({12'h43F, 5'd1, 3'b101, 5'd3, 7'b0010011}, 64'h18, 64'h77, 64'h0);
    chk_bundle("srai", 64'h77, 64'd63, 4'b1101, 1'b0);
    issue({12'h400, 5'd1, 3'b000, 5'd3, 7'b0010011}, 64'h1C, 64'h5, 64'h0);
    chk_bundle("addi_400", 64'h5, 64'h400, 4'b0000, 1'b0);
    issue({12'hC00, 5'd1, 3'b000, 5'd3, 7'b0010011}, 64'h20, 64'h5, 64'h0);
    chk_bundle("addi_c00", 64'h5, 64'hFFFF_FFFF_FFFF_FC00, 4'b0000, 1'b0);
    issue({20'h80000, 5'd3, 7'b0010111}, 64'h1000, 64'h9, 64'h9);
    chk_bundle("auipc", 64'h1000, 64'hFFFF_FFFF_8000_0000, 4'b0000, 1'b0);
    issue({7'b0000001, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011}, 64'h24, 64'h3, 64'h4);
    chk_bundle("mul_ill", 64'h0, 64'h0, 4'b0000, 1'b1);
    issue({12'h010, 5'd1, 3'b011, 5'd3, 7'b0000011}, 64'h28, 64'h3, 64'h4);
    chk_bundle("load_ill", 64'h0, 64'h0, 4'b0000, 1'b1);
    cycle();
    cycle();

    // Backpressure: four offered bundles while the ALU stalls.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      instr = rand_instr(); pc = 64'h100 + 64'(4 * i); rs1 = {$urandom(), $urandom()};
      rs2 = {$urandom(), $urandom()};
      rdy[3 - i] = in_ready;
      if (i > 0) chk("bp_hold_pc", pc_out, 64'h100);
      cycle();
    end
    chk("bp_ready_pattern", 64'(rdy), 64'(4'b1100));
    chk("bp_hold_pc_end", pc_out, 64'h100);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("bp_first", pc_out, 64'h100);
    cycle();
    chk("bp_second", pc_out, 64'h104);
    cycle();
    chk("bp_drained", 64'(out_valid), 64'd0);
    cycle();

    // Flush with both entries occupied; the input offered alongside is dropped.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      instr = rand_instr(); pc = 64'h200 + 64'(4 * i);
      cycle();
    end
    chk("pre_flush_full", 64'(in_ready), 64'd0);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", 64'(out_valid), 64'd0);
    chk("flush_ready", 64'(in_ready), 64'd1);
    cycle();

    // Randomized stream with random backpressure and occasional flush.
    for (int n = 0; n < 300; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 49) == 0);
      instr = rand_instr(); pc = {$urandom(), $urandom()};
      rs1 = {$urandom(), $urandom()}; rs2 = {$urandom(), $urandom()};
      cycle();
    end
    flush = 1'b0;

    // Reset dropped mid-stream, away from any clock edge.
    in_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      instr = rand_instr(); pc = 64'h300 + 64'(4 * i);
      cycle();
    end
    #2 rst_n = 1'b0;
    #1 chk_reset("mid_reset");
    q.delete();
    in_valid = 1'b0;
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      in_valid = ($urandom_range(0, 1) != 0);
      instr = rand_instr(); pc = {$urandom(), $urandom()};
      rs1 = {$urandom(), $urandom()}; rs2 = {$urandom(), $urandom()};
      cycle();
    end
    in_valid = 1'b0;
    cycle();
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
